// File: rtl/fft_pkg.sv
// Shared FFT datapath types, sizes and the sum/diff arithmetic helper.
// BFLY10_SAT_EN selects saturation in sat_add_w; two's-complement wrap otherwise.
package fft_pkg;

    localparam int FFT_LANES = 16;
    localparam int FFT_WIDTH = 12;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    typedef cplx_t [FFT_LANES-1:0] cplx_vec_t;

    typedef enum logic {
        FILL = 1'b0,
        CALC = 1'b1
    } bfly_state_t;

    // a+b (sub=0) or a-b (sub=1) at full WIDTH+1 precision, then
    // reduced back to WIDTH bits.
    function automatic logic signed [FFT_WIDTH-1:0] sat_add_w(
        input logic signed [FFT_WIDTH-1:0] a,
        input logic signed [FFT_WIDTH-1:0] b,
        input logic                        sub
    );
        logic signed [FFT_WIDTH:0] ae;
        logic signed [FFT_WIDTH:0] be;
        logic signed [FFT_WIDTH:0] r;
        ae = {a[FFT_WIDTH-1], a};
        be = {b[FFT_WIDTH-1], b};
        r  = sub ? (ae - be) : (ae + be);
`ifdef BFLY10_SAT_EN
        // Top two bits disagree only when the result left the WIDTH range.
        if (r[FFT_WIDTH] != r[FFT_WIDTH-1]) begin
            if (r[FFT_WIDTH]) begin
                return {1'b1, {(FFT_WIDTH-1){1'b0}}};
            end
            return {1'b0, {(FFT_WIDTH-1){1'b1}}};
        end
`endif
        return r[FFT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/bfly10_stage_if.sv
// Stage-9 input vector and butterfly sum/diff output bundle.
// slave: the butterfly stage; master: the block driving inputs and taking results.
interface bfly10_stage_if
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int LANES = FFT_LANES
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_re [LANES];
    logic signed [WIDTH-1:0] in_im [LANES];

    logic                    o_bfly_valid;
    logic                    o_bfly_last;
    logic signed [WIDTH-1:0] o_bfly_sum_re  [LANES];
    logic signed [WIDTH-1:0] o_bfly_sum_im  [LANES];
    logic signed [WIDTH-1:0] o_bfly_diff_re [LANES];
    logic signed [WIDTH-1:0] o_bfly_diff_im [LANES];

    modport master (
        output in_valid, in_re, in_im,
        input  o_bfly_valid, o_bfly_last,
        input  o_bfly_sum_re, o_bfly_sum_im,
        input  o_bfly_diff_re, o_bfly_diff_im
    );

    modport slave (
        input  in_valid, in_re, in_im,
        output o_bfly_valid, o_bfly_last,
        output o_bfly_sum_re, o_bfly_sum_im,
        output o_bfly_diff_re, o_bfly_diff_im
    );
endinterface

// File: rtl/bfly10_buf.sv
// Half-block storage: DEPTH words of DW bits, synchronous write, combinational read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module bfly10_buf #(
    parameter int DEPTH = 16,
    parameter int DW    = 384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // No reset: every word is rewritten during FILL before CALC reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bfly10_stage.sv
// Radix-2 butterfly feeding the stage-10 twiddle block: buffers the first half of a block,
// then emits per-lane sum=a+b / diff=a-b one clock after each second-half input.
// Ports: clk, rst (sync, active-high), bus (bfly10_stage_if.slave: in_valid/in_re/in_im,
// o_bfly_valid/o_bfly_last/o_bfly_sum_*/o_bfly_diff_*).
// Build option: BFLY10_SAT_EN saturates results instead of wrapping.
module bfly10_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int DEPTH = 16,
    parameter int LANES = FFT_LANES
) (
    input  logic           clk,
    input  logic           rst,
    bfly10_stage_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $bits(cplx_vec_t);

    bfly_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic cnt_last;
    logic buf_we;
    logic calc_en;
    logic calc_last;

    cplx_vec_t in_vec;
    cplx_vec_t a_vec;

    logic                    valid_q;
    logic                    last_q;
    logic signed [WIDTH-1:0] sum_re_q  [LANES];
    logic signed [WIDTH-1:0] sum_im_q  [LANES];
    logic signed [WIDTH-1:0] diff_re_q [LANES];
    logic signed [WIDTH-1:0] diff_im_q [LANES];

    assign cnt_last = (cnt_q == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt is a power-of-2 modulus, so the natural wrap returns it to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.in_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_last) begin
                unique case (state_q)
                    FILL:    state_d = CALC;
                    CALC:    state_d = FILL;
                    default: state_d = FILL;
                endcase
            end
        end
    end

    always_comb begin
        buf_we    = 1'b0;
        calc_en   = 1'b0;
        calc_last = 1'b0;
        unique case (state_q)
            FILL: buf_we = bus.in_valid;
            CALC: begin
                calc_en   = bus.in_valid;
                calc_last = bus.in_valid & cnt_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_vec = '0;
        for (int l = 0; l < LANES; l++) begin
            in_vec[l].re = bus.in_re[l];
            in_vec[l].im = bus.in_im[l];
        end
    end

    // Same counter addresses both sides; write happens only in FILL,
    // read is used only in CALC.
    bfly10_buf #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt_q),
        .wdata (in_vec),
        .raddr (cnt_q),
        .rdata (a_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                sum_re_q[l]  <= '0;
                sum_im_q[l]  <= '0;
                diff_re_q[l] <= '0;
                diff_im_q[l] <= '0;
            end
        end else begin
            valid_q <= calc_en;
            last_q  <= calc_last;
            if (calc_en) begin
                for (int l = 0; l < LANES; l++) begin
                    sum_re_q[l]  <= sat_add_w(a_vec[l].re, in_vec[l].re, 1'b0);
                    sum_im_q[l]  <= sat_add_w(a_vec[l].im, in_vec[l].im, 1'b0);
                    diff_re_q[l] <= sat_add_w(a_vec[l].re, in_vec[l].re, 1'b1);
                    diff_im_q[l] <= sat_add_w(a_vec[l].im, in_vec[l].im, 1'b1);
                end
            end
        end
    end

    assign bus.o_bfly_valid   = valid_q;
    assign bus.o_bfly_last    = last_q;
    assign bus.o_bfly_sum_re  = sum_re_q;
    assign bus.o_bfly_sum_im  = sum_im_q;
    assign bus.o_bfly_diff_re = diff_re_q;
    assign bus.o_bfly_diff_im = diff_im_q;
endmodule

// File: doc/bfly10_stage.md
Name: bfly10_stage

Overview:
- Radix-2 butterfly stage that produces the 16-lane sum/diff vectors and valid strobe consumed by the stage-10 twiddle multiplier.
- Buffers the first half of each block (DEPTH cycles × 16 complex lanes).
- Combines that half with the second half, lane by lane and cycle by cycle: sum = a+b, diff = a−b.
- Sits between the stage-9 output and the stage-10 twiddle block in the FFT datapath.

Parameters:
- WIDTH, 12: sample width, signed <6.6>, for both input and output.
- DEPTH, 16: cycles per half-block; also the buffer depth in 16-lane words. Must be a power of 2, ≥2.
- LANES, 16: complex lanes per cycle. Fixed at 16 to match the downstream interface.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid this cycle.
- in_re[0:15]  in  WIDTH each  input real, signed.
- in_im[0:15]  in  WIDTH each  input imag, signed.
- o_bfly_valid  out  1  sum/diff outputs valid; drives the downstream twd10_valid.
- o_bfly_last  out  1  high with the final valid output of a block.
- o_bfly_sum_re[0:15]  out  WIDTH each  a+b real.
- o_bfly_sum_im[0:15]  out  WIDTH each  a+b imag.
- o_bfly_diff_re[0:15]  out  WIDTH each  a−b real.
- o_bfly_diff_im[0:15]  out  WIDTH each  a−b imag.

Behaviour:
- Reset: one clock (clk); reset is synchronous, active-high (rst). While rst=1 at a rising edge:
  - state=FILL, cnt=0;
  - o_bfly_valid=0, o_bfly_last=0;
  - all sum/diff outputs=0.
  - Buffer contents are don't-care and are never read before being rewritten.
- FSM has two states, FILL and CALC. cnt is log2(DEPTH) bits and advances only on cycles with in_valid=1.
- FILL:
  - Each in_valid cycle writes the input vector to buf[cnt] and increments cnt.
  - When cnt==DEPTH−1 and in_valid=1: cnt wraps to 0, state→CALC.
  - o_bfly_valid=0 throughout FILL.
- CALC:
  - Each in_valid cycle reads a=buf[cnt], takes b=input, and registers, per lane: sum_re=a_re+b_re, sum_im=a_im+b_im, diff_re=a_re−b_re, diff_im=a_im−b_im.
  - o_bfly_valid=1 on the next cycle; cnt increments.
  - When cnt==DEPTH−1 and in_valid=1: o_bfly_last=1 on the next cycle, cnt→0, state→FILL.
- Latency: exactly 1 clock from a CALC-state input to its output. Output cycle k of a block pairs input cycle k with input cycle DEPTH+k.
- in_valid gaps (in_valid=0) in either state:
  - state, cnt and buffer hold;
  - o_bfly_valid=0 and o_bfly_last=0 next cycle;
  - data outputs hold their last values.
- Back-to-back blocks: a FILL input may arrive the cycle after the last CALC input with no bubble. Output valid is then low for DEPTH cycles while the next block fills.
- Arithmetic:
  - The WIDTH+1-bit full-precision result is computed by sign-extending both operands.
  - Default behaviour: wrap, i.e. keep the WIDTH LSBs. No scaling; the <6.6> format is preserved.
- Reset mid-block: the partial block is discarded, FSM returns to FILL with cnt=0, and no output is generated for the discarded block.
- Buffer is written only in FILL and read only in CALC, so the same address is never read and written in the same cycle.
- Buffer implementation is single-port; registers or inferred RAM are both permitted.

Optional Feature:
- Macro: BFLY10_SAT_EN.
- Defined: each WIDTH+1 result that falls outside [−2^(WIDTH−1), 2^(WIDTH−1)−1] saturates to the nearest bound, per component, independently.
- Undefined: two's-complement wrap as above.
- Latency and ports are identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - FFT_LANES=16 and FFT_WIDTH=12;
  - typedef cplx_t, a struct of signed re and im of FFT_WIDTH;
  - typedef cplx_vec_t, cplx_t[FFT_LANES];
  - function sat_add_w, used for sum and diff, with saturate/wrap chosen by the macro.
- One natural sub-module, bfly10_buf: a DEPTH×(LANES·2·WIDTH) storage array with write enable, write address, read address and registered-free read.
- FSM, counter and arithmetic stay in bfly10_stage.

Test Plan:
- Basic block (DEPTH=16): continuous in_valid for 32 cycles. Cycle k<16: all lanes re=k, im=−k. Cycle 16+k: re=2, im=1.
  → Outputs on cycles 17..32: sum_re=k+2, sum_im=1−k, diff_re=k−2, diff_im=−k−1. o_bfly_valid high 16 cycles; o_bfly_last only at the 16th output.
- Gaps: same stimulus with in_valid=0 on every third cycle.
  → Identical 16 output values in order; o_bfly_valid low exactly one cycle after each gap; outputs hold during gaps.
- Back-to-back: 4 contiguous blocks with lane-dependent data (re=lane+16·cycle).
  → 64 valid outputs matching the reference model; valid pattern is 16 off / 16 on repeating.
- Overflow: a re=2047, b re=1 on all lanes; a re=−2048, b re=1.
  → Default build: sum=−2048 (wrap), diff=−2048−1 wraps to 2047. With BFLY10_SAT_EN: sum=2047, diff=−2048.
- Reset mid-block: rst=1 for 1 cycle after 10 CALC inputs, then a fresh 32-cycle block.
  → No valid output during or after reset until cycle 17 of the new block; results contain no stale data.
- Reset values: assert rst with random inputs and in_valid=1.
  → All outputs 0, o_bfly_valid=0 while rst is held.
